// File: rtl/tmds_channel_encoder_if.sv
// Pixel-side bundle of one TMDS channel encoder: colour/control inputs and the
// encoded character with its aligned DE and running-disparity observation.
interface tmds_channel_encoder_if #(
  parameter int DISP_W = 5
);
  logic [7:0]        i_data;
  logic              i_de;
  logic              i_c0;
  logic              i_c1;
  logic [9:0]        o_tx_word;
  logic              o_de;
  logic [DISP_W-1:0] o_disp;

  modport master (
    output i_data, i_de, i_c0, i_c1,
    input  o_tx_word, o_de, o_disp
  );

  modport slave (
    input  i_data, i_de, i_c0, i_c1,
    output o_tx_word, o_de, o_disp
  );
endinterface

// File: rtl/tmds_channel_encoder.sv
// DVI/TMDS channel encoder: stage 1 does transition minimisation, stage 2 does
// running-disparity DC balance or emits a control token. Fixed 2-clock latency.
module tmds_channel_encoder #(
  parameter logic [9:0] RESET_WORD = 10'h354,
  parameter int         DISP_W     = 5
) (
  input logic                   i_clk,
  input logic                   i_rstn,
  tmds_channel_encoder_if.slave bus
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  // XNOR chaining is chosen when it yields fewer transitions; q_m[8] records the choice.
  function automatic logic [8:0] transition_min(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  // Stage 1
  logic       s1_de;
  logic [1:0] s1_ctrl;
  logic [8:0] s1_qm;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s1_de   <= 1'b0;
      s1_ctrl <= 2'b00;
      s1_qm   <= '0;
    end else begin
      s1_de   <= bus.i_de;
      s1_ctrl <= {bus.i_c1, bus.i_c0};
      s1_qm   <= transition_min(bus.i_data);
    end
  end

  // Stage 2
  logic                     q8;
  logic [7:0]               qm;
  logic [3:0]               qm_ones;
  logic signed [DISP_W-1:0] bal;       // n1 - n0 of q_m[7:0]
  logic signed [DISP_W-1:0] cnt;
  logic signed [DISP_W-1:0] cnt_next;
  logic [9:0]               word_next;
  logic [9:0]               tx_word;
  logic                     de_q;
  logic                     cnt_pos, cnt_neg, bal_pos, bal_neg;

  // NOTE: every variable gets a default at the top of the always_comb so no
  // path through the branches can infer a latch.
  always_comb begin
    q8        = s1_qm[8];
    qm        = s1_qm[7:0];
    qm_ones   = popcount8(qm);
    bal       = DISP_W'({qm_ones, 1'b0}) - DISP_W'(8);
    cnt_pos   = !cnt[DISP_W-1] && (cnt != '0);
    cnt_neg   = cnt[DISP_W-1];
    bal_pos   = !bal[DISP_W-1] && (bal != '0);
    bal_neg   = bal[DISP_W-1];
    word_next = RESET_WORD;
    cnt_next  = cnt;

    if (!s1_de) begin
      unique case (s1_ctrl)
        2'b00: word_next = 10'h354;
        2'b01: word_next = 10'h0AB;
        2'b10: word_next = 10'h154;
        2'b11: word_next = 10'h2AB;
      endcase
      cnt_next = '0;
    end else if ((cnt == '0) || (bal == '0)) begin
      word_next = {~q8, q8, q8 ? qm : ~qm};
      cnt_next  = q8 ? (cnt + bal) : (cnt - bal);
    end else if ((cnt_pos && bal_pos) || (cnt_neg && bal_neg)) begin
      word_next = {1'b1, q8, ~qm};
      cnt_next  = cnt + (q8 ? DISP_W'(2) : '0) - bal;
    end else begin
      word_next = {1'b0, q8, qm};
      cnt_next  = cnt + bal - (q8 ? '0 : DISP_W'(2));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      tx_word <= RESET_WORD;
      de_q    <= 1'b0;
      cnt     <= '0;
    end else begin
      tx_word <= word_next;
      de_q    <= s1_de;
      cnt     <= cnt_next;
    end
  end

  assign bus.o_tx_word = tx_word;
  assign bus.o_de      = de_q;
  assign bus.o_disp    = cnt;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: directed vectors with hand-computed
// characters, a reset-in-burst case, and a random run checked by a reference decoder.
module tb_tmds_channel_encoder;

  typedef enum logic {EXP_EXACT, EXP_DECODE} exp_kind_e;

  typedef struct {
    int         due;
    exp_kind_e  kind;
    logic [9:0] word;
    logic       de;
    int         disp;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  tmds_channel_encoder_if bus ();

  tmds_channel_encoder dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)",
               name, cyc, act, act, exp, exp);
    end
  endtask

  function automatic logic [9:0] token(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic push_exact(input int ofs, input logic [9:0] w, input logic de, input int disp);
    exp_t e;
    e.due = cyc + ofs; e.kind = EXP_EXACT; e.word = w; e.de = de; e.disp = disp; e.data = '0;
    sb.push_back(e);
  endtask

  task automatic push_decode(input int ofs, input logic [7:0] d);
    exp_t e;
    e.due = cyc + ofs; e.kind = EXP_DECODE; e.word = '0; e.de = 1'b1; e.disp = 0; e.data = d;
    sb.push_back(e);
  endtask

  task automatic drive(input logic r, input logic de, input logic [1:0] c, input logic [7:0] d);
    rstn        = r;
    bus.i_de    = de;
    bus.i_c1    = c[1];
    bus.i_c0    = c[0];
    bus.i_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] d, input logic [9:0] w, input int disp);
    push_exact(2, w, 1'b1, disp);
    drive(1'b1, 1'b1, 2'b00, d);
  endtask

  task automatic ctl(input logic [1:0] c);
    push_exact(2, token(c), 1'b0, 0);
    drive(1'b1, 1'b0, c, 8'h00);
  endtask

  // Monitor: pops every expectation whose output cycle has come.
  exp_t cur;
  int   dsp;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      dsp = $signed(bus.o_disp);
      if (cur.due != cyc) begin
        check("due_cycle", cyc, cur.due);
      end else if (cur.kind == EXP_EXACT) begin
        check("tx_word", bus.o_tx_word, cur.word);
        check("o_de",    bus.o_de,      cur.de);
        check("o_disp",  $signed(bus.o_disp), cur.disp);
      end else begin
        check("decoded_byte", tmds_decode(bus.o_tx_word), cur.data);
        check("o_de",         bus.o_de, 1'b1);
        check("disp_bound",   (dsp <= 10 && dsp >= -10), 1'b1);
      end
    end
  end

  initial begin
    logic       rde;
    logic [1:0] rc;
    logic [7:0] rd;
    int         waited;

    rstn = 1'b0; bus.i_de = 1'b0; bus.i_c0 = 1'b0; bus.i_c1 = 1'b0; bus.i_data = 8'h00;
    @(posedge clk);
    #1;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      push_exact(1, 10'h354, 1'b0, 0);
      drive(1'b0, 1'($urandom), 2'($urandom), 8'($urandom));
    end

    // Control tokens
    ctl(2'b00); ctl(2'b01); ctl(2'b10); ctl(2'b11);

    // 0x00 twice from cnt=0, then back to control
    pix(8'h00, 10'h100, -8);
    pix(8'h00, 10'h3FF,  2);
    ctl(2'b00);

    // 0xFF then control clears disparity
    pix(8'hFF, 10'h200, -8);
    ctl(2'b00);

    // Each balance branch, both q_m[8] values
    pix(8'h01, 10'h1FF,  8);
    pix(8'h01, 10'h300,  2);
    pix(8'h55, 10'h133,  2);
    pix(8'hAA, 10'h233,  2);
    pix(8'h10, 10'h1F0,  2);
    pix(8'h80, 10'h180, -4);
    pix(8'h80, 10'h37F,  4);
    pix(8'hF8, 10'h002, -4);
    pix(8'hF8, 10'h2FD,  2);
    ctl(2'b01);

    // Reset for one clock in a burst: the in-flight word is discarded
    ctl(2'b00);
    pix(8'h00, 10'h100, -8);
    drive(1'b1, 1'b1, 2'b00, 8'h00);
    push_exact(1, 10'h354, 1'b0, 0);
    push_exact(2, 10'h354, 1'b0, 0);
    drive(1'b0, 1'b1, 2'b00, 8'h00);
    pix(8'h00, 10'h100, -8);
    pix(8'h00, 10'h3FF,  2);
    ctl(2'b00);

    // Random pixels with DE gaps, checked by decoding
    for (int i = 0; i < 3000; i++) begin
      rde = ($urandom_range(0, 4) != 0);
      rc  = 2'($urandom);
      rd  = 8'($urandom);
      if (rde) push_decode(2, rd);
      else     push_exact(2, token(rc), 1'b0, 0);
      drive(1'b1, rde, rc, rd);
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
